comb_sweep_ctrl: RTL and testbench



---
 rtl/comb_sweep_ctrl.sv | 123 ++++++++++++
 tb/tb_comb_sweep_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_sweep_ctrl.sv
// Sweep controller for small combinational circuits: steps through every input
// vector, waits a settle time, captures the output and compares against a golden table.
module comb_sweep_ctrl #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 7,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(1<<N_IN)-1:0]   expected,
    input  logic                   dut_out,
    output logic [N_IN-1:0]        dut_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   truth_table
);

    localparam int               NV        = 1 << N_IN;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam logic [N_IN-1:0]  IDX_LAST  = N_IN'(NV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    state_t            load_state;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic [NV-1:0]     tt_q, tt_d;
    logic [NV-1:0]     exp_q, exp_d;
    logic              pass_q, pass_d;

    // With no settle time every vector goes straight to its capture cycle.
    assign load_state = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            dut_in_q <= '0;
            tt_q     <= '0;
            exp_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dut_in_q <= dut_in_d;
            tt_q     <= tt_d;
            exp_q    <= exp_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dut_in_d = dut_in_q;
        tt_d     = tt_q;
        exp_d    = exp_q;
        pass_d   = pass_q;

        // Abort overrides everything; the partial truth table is kept for debug.
        if (state_q != IDLE && abort) begin
            state_d  = IDLE;
            dut_in_d = '0;
            pass_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_d    = '0;
                        dut_in_d = '0;
                        tt_d     = '0;
                        pass_d   = 1'b0;
                        exp_d    = expected;
                        cnt_d    = SETTLE_LD;
                        state_d  = load_state;
                    end
                end
                SETTLE: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    tt_d[idx_q] = dut_out;
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        dut_in_d = idx_q + 1'b1;
                        cnt_d    = SETTLE_LD;
                        state_d  = load_state;
                    end
                end
                DONE: begin
                    pass_d  = (tt_q == exp_q);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign dut_in      = dut_in_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign pass        = pass_q;
    assign truth_table = tt_q;

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Scoreboard bench for comb_sweep_ctrl: three instances (settle 7, 0, 5) each
// driving a modelled 3-input circuit; one is selected at a time by sel.
module tb_comb_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] expected;
    int         sel;
    int         func;          // 0 majority, 1 xor3, 2 and3, 3 majority delayed 7 cycles

    logic [2:0] din_a  [3];
    logic       dout_a [3];
    logic       busy_a [3];
    logic       done_a [3];
    logic       pass_a [3];
    logic [7:0] tt_a   [3];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [7:0] tt;
        logic       ps;
        int         k;
        int         lat;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic circ(input int fn, input logic [2:0] x);
        case (fn)
            1:       return ^x;
            2:       return &x;
            default: return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
        endcase
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        logic [6:0] dly = '0;
        always @(posedge clk) dly <= {dly[5:0], circ(func, din_a[gi])};
        assign dout_a[gi] = (func == 3) ? dly[6] : circ(func, din_a[gi]);

        comb_sweep_ctrl #(
            .N_IN          (3),
            .SETTLE_CYCLES ((gi == 0) ? 7 : (gi == 1) ? 0 : 5),
            .CNT_W         (8)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (start && (sel == gi)),
            .abort       (abort && (sel == gi)),
            .expected    (expected),
            .dut_out     (dout_a[gi]),
            .dut_in      (din_a[gi]),
            .busy        (busy_a[gi]),
            .done        (done_a[gi]),
            .pass        (pass_a[gi]),
            .truth_table (tt_a[gi])
        );
    end

    logic       m_busy, m_done, m_pass;
    logic [2:0] m_din;
    logic [7:0] m_tt;
    always_comb begin
        m_busy = busy_a[sel];
        m_done = done_a[sel];
        m_pass = pass_a[sel];
        m_din  = din_a[sel];
        m_tt   = tt_a[sel];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", nm, act, cyc);
        end
    endtask

    // Monitor: on each done pulse pop the oldest expectation; pass is checked
    // the following cycle because it is registered on leaving DONE.
    logic pend = 1'b0;
    logic pend_ps;
    exp_t e;
    always @(negedge clk) begin
        if (pend) begin
            chk("pass_after_done", 32'(m_pass), 32'(pend_ps));
            chk("busy_after_done", 32'(m_busy), 32'd0);
            pend = 1'b0;
        end
        if (rst_n && m_done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'(m_done), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("truth_table", 32'(m_tt), 32'(e.tt));
                chk("done_latency", 32'(cyc - e.k), 32'(e.lat));
                chk("busy_at_done", 32'(m_busy), 32'd1);
                pend    = 1'b1;
                pend_ps = e.ps;
            end
        end
    end

    task automatic launch(input logic [7:0] exp_in, input logic [7:0] tt, input logic ps,
                          input int lat, input bit push, output int k);
        exp_t x;
        @(negedge clk);
        expected = exp_in;
        start    = 1'b1;
        k        = cyc + 1;
        if (push) begin
            x.tt = tt; x.ps = ps; x.k = k; x.lat = lat;
            sbq.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !m_busy) break;
        end
        chk("sweep_idle", 32'(sbq.size() == 0 && !m_busy), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, 32'(m_busy), 32'd0);
        chk({nm, "_done"}, 32'(m_done), 32'd0);
        chk({nm, "_pass"}, 32'(m_pass), 32'd0);
        chk({nm, "_dut_in"}, 32'(m_din), 32'd0);
        chk({nm, "_tt"}, 32'(m_tt), 32'd0);
    endtask

    initial begin
        int k;
        exp_t x;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = 8'h00;
        sel = 0; func = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1 chk_zero("reset");
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Majority, settle 7: dut_in steps every 8 cycles; a mid-sweep start is ignored.
        launch(8'hE8, 8'hE8, 1'b1, 64, 1'b1, k);
        for (int v = 0; v < 8; v++) begin
            wait_cyc(k + 8 * v + 4);
            chk("dut_in_step", 32'(m_din), 32'(v));
            if (v == 2) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        wait_idle(100);

        // XOR3 against majority golden; expected changed after start must not matter.
        func = 1;
        launch(8'hE8, 8'h96, 1'b0, 64, 1'b1, k);
        expected = 8'h96;
        wait_idle(100);

        // AND3, settle 0: start with abort in IDLE still starts; held start re-triggers.
        sel = 1; func = 2;
        repeat (3) @(negedge clk);
        expected = 8'h80; start = 1'b1; abort = 1'b1;
        k = cyc + 1;
        x.tt = 8'h80; x.ps = 1'b1; x.k = k; x.lat = 8;
        sbq.push_back(x);
        x.k = k + 10;
        sbq.push_back(x);
        @(negedge clk);
        abort = 1'b0;
        wait_cyc(k + 11);
        start = 1'b0;
        wait_idle(50);

        // Circuit with 7-cycle output delay: settle 7 captures fresh, settle 5 stale.
        sel = 0; func = 3;
        repeat (10) @(negedge clk);
        launch(8'hE8, 8'hE8, 1'b1, 64, 1'b1, k);
        wait_idle(100);
        sel = 2;
        repeat (10) @(negedge clk);
        launch(8'hE8, 8'hD0, 1'b0, 48, 1'b1, k);
        wait_idle(100);

        // Abort while idx=4: partial table kept, outputs return to idle values.
        sel = 0; func = 0;
        repeat (3) @(negedge clk);
        launch(8'hE8, 8'h00, 1'b0, 0, 1'b0, k);
        wait_cyc(k + 33);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(m_busy), 32'd0);
        chk("abort_dut_in", 32'(m_din), 32'd0);
        chk("abort_tt", 32'(m_tt), 32'h08);
        chk("abort_pass", 32'(m_pass), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'd6);
        launch(8'hE8, 8'hE8, 1'b1, 64, 1'b1, k);
        wait_idle(100);

        // Asynchronous reset mid-sweep: everything clears between clock edges.
        launch(8'hE8, 8'h00, 1'b0, 0, 1'b0, k);
        wait_cyc(k + 30);
        chk("pre_reset_busy", 32'(m_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("total_done_pulses", 32'(done_cnt), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
